controle_multiciclo: RTL and testbench
======================================

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 clock  in  1  sole clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-low reset.
REQ-003 OPcode  in  6  instruction bits 31:26 from instruction register.
REQ-004 Overflow  in  1  combinational ALU overflow flag of current cycle.
REQ-005 EscreveMem  out  1  memory write strobe.
REQ-006 EscrevePC  out  1  unconditional PC load.
REQ-007 EscrevePCCond  out  1  conditional PC load, qualified externally by ALU zero.
REQ-008 PCCondNe  out  1  1 = PC condition uses inverted zero (bne).
REQ-009 OrigPC  out  2  PC source: 00 ALU, 01 AluOut, 10 jump target, 11 exception vector.
REQ-010 RegDst  out  1  0 = rt, 1 = rd.
REQ-011 EscreveReg  out  1  register-file write enable.
REQ-012 MemparaReg  out  1  0 = AluOut, 1 = MDR to register file.
REQ-013 IouD  out  1  memory address: 0 = PC, 1 = AluOut.
REQ-014 EscreveIR  out  1  instruction register load.
REQ-015 EscreveMDR  out  1  MDR load.
REQ-016 EscreveAluOut  out  1  AluOut load.
REQ-017 OrigAALU  out  1  ALU A: 0 = PC, 1 = reg A.
REQ-018 OrigBALU  out  2  ALU B: 00 reg B, 01 const 4, 10 sign-ext, 11 sign-ext<<2.
REQ-019 OpALU  out  3  000 add, 001 sub, 010 decode by funct.
REQ-020 EscreveEPC  out  1  EPC load.
REQ-021 State  out  6  current state encoding.

Function
REQ-022 All outputs SHALL be Moore-decoded from current state only; every output not listed for a state SHALL be 0.
REQ-023 States/encodings: RESET 0, FETCH 1, FETCH_WAIT 2, DECODE 3, MEM_ADDR 4, MEM_READ 5, MEM_WAIT 6, LW_WB 7, SW_WRITE 8, R_EXEC 9, R_WB 10, BRANCH 11, JUMP 12, ADDI_EXEC 13, ADDI_WB 14, EXC_OVF 15, EXC_OPC 16.
REQ-024 RESET -> FETCH unconditionally.
REQ-025 FETCH: IouD=0, OrigAALU=0, OrigBALU=01, OpALU=000, OrigPC=00, EscrevePC=1; -> FETCH_WAIT (memory read latency 1 cycle).
REQ-026 FETCH_WAIT: EscreveIR=1; -> DECODE.
REQ-027 DECODE: OrigAALU=0, OrigBALU=11, OpALU=000, EscreveAluOut=1; dispatch on OPcode: 0x00 R_EXEC, 0x23/0x2B MEM_ADDR, 0x04/0x05 BRANCH, 0x02 JUMP, 0x08 ADDI_EXEC, other EXC_OPC.
REQ-028 MEM_ADDR: OrigAALU=1, OrigBALU=10, OpALU=000, EscreveAluOut=1; -> MEM_READ if 0x23, SW_WRITE if 0x2B.
REQ-029 MEM_READ: IouD=1; -> MEM_WAIT. MEM_WAIT: IouD=1, EscreveMDR=1; -> LW_WB. LW_WB: RegDst=0, MemparaReg=1, EscreveReg=1; -> FETCH.
REQ-030 SW_WRITE: IouD=1, EscreveMem=1; -> FETCH.
REQ-031 R_EXEC: OrigAALU=1, OrigBALU=00, OpALU=010, EscreveAluOut=1; -> EXC_OVF if Overflow=1, else R_WB. R_WB: RegDst=1, MemparaReg=0, EscreveReg=1; -> FETCH.
REQ-032 ADDI_EXEC: OrigAALU=1, OrigBALU=10, OpALU=000, EscreveAluOut=1; -> EXC_OVF if Overflow=1, else ADDI_WB. ADDI_WB: RegDst=0, MemparaReg=0, EscreveReg=1; -> FETCH.
REQ-033 BRANCH: OrigAALU=1, OrigBALU=00, OpALU=001, OrigPC=01, EscrevePCCond=1, PCCondNe=(OPcode==0x05); -> FETCH. JUMP: OrigPC=10, EscrevePC=1; -> FETCH.
REQ-034 EXC_OVF/EXC_OPC: OrigAALU=0, OrigBALU=01, OpALU=001, EscreveEPC=1, OrigPC=11, EscrevePC=1; -> FETCH; EscreveReg SHALL never assert on an overflowing instruction.

Reset
REQ-035 reset=0 at a rising edge SHALL force State=RESET from any state, including mid-instruction; all outputs 0 in RESET; no write strobe asserts in the cycle after reset is sampled low.

Configuration
REQ-036 CONTROLE_EXCECAO_EN defined: REQ-031/032/034 as stated. Undefined: Overflow ignored (R_EXEC->R_WB, ADDI_EXEC->ADDI_WB), unknown OPcode in DECODE -> FETCH, states 15/16 unreachable, EscreveEPC constant 0.

Structure
REQ-037 Shared package SHALL hold state enum, opcode constants, OpALU/OrigPC/OrigBALU encodings; no sub-module, single FSM.

Verification
REQ-038 Reset low 3 cycles, release -> State 0 then 1; outputs 0 during reset.
REQ-039 OPcode 0x23 -> states 1,2,3,4,5,6,7,1; EscreveMDR only in 6, EscreveReg only in 7 with MemparaReg=1.
REQ-040 OPcode 0x2B -> 1,2,3,4,8,1; EscreveMem=1 only in 8 with IouD=1.
REQ-041 OPcode 0x05 -> BRANCH with PCCondNe=1, EscrevePCCond=1, OrigPC=01; 0x04 -> PCCondNe=0.
REQ-042 Macro defined: OPcode 0x00, Overflow=1 in R_EXEC -> 9,15,1, EscreveReg never 1; OPcode 0x3F -> 3,16,1. Macro undefined: same stimuli -> 9,10,1 and 3,1.
REQ-043 reset=0 during state 6 -> State 0 next cycle, EscreveReg stays 0.

Source files
------------

// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes and datapath mux/ALU selects.
`default_nettype none

package controle_multiciclo_pkg;

    typedef logic [5:0] state_t;

    localparam state_t S_RESET      = 6'd0;
    localparam state_t S_FETCH      = 6'd1;
    localparam state_t S_FETCH_WAIT = 6'd2;
    localparam state_t S_DECODE     = 6'd3;
    localparam state_t S_MEM_ADDR   = 6'd4;
    localparam state_t S_MEM_READ   = 6'd5;
    localparam state_t S_MEM_WAIT   = 6'd6;
    localparam state_t S_LW_WB      = 6'd7;
    localparam state_t S_SW_WRITE   = 6'd8;
    localparam state_t S_R_EXEC     = 6'd9;
    localparam state_t S_R_WB       = 6'd10;
    localparam state_t S_BRANCH     = 6'd11;
    localparam state_t S_JUMP       = 6'd12;
    localparam state_t S_ADDI_EXEC  = 6'd13;
    localparam state_t S_ADDI_WB    = 6'd14;
    localparam state_t S_EXC_OVF    = 6'd15;
    localparam state_t S_EXC_OPC    = 6'd16;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_EXC    = 2'b11;

    localparam logic [1:0] B_REG      = 2'b00;
    localparam logic [1:0] B_FOUR     = 2'b01;
    localparam logic [1:0] B_SEXT     = 2'b10;
    localparam logic [1:0] B_SEXT_SH2 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-subset control FSM with Moore-decoded datapath controls.
// Macro CONTROLE_EXCECAO_EN enables overflow / illegal-opcode exception states.
`default_nettype none

module controle_multiciclo
    import controle_multiciclo_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] OPcode,
    input  logic       Overflow,
    output logic       EscreveMem,
    output logic       EscrevePC,
    output logic       EscrevePCCond,
    output logic       PCCondNe,
    output logic [1:0] OrigPC,
    output logic       RegDst,
    output logic       EscreveReg,
    output logic       MemparaReg,
    output logic       IouD,
    output logic       EscreveIR,
    output logic       EscreveMDR,
    output logic       EscreveAluOut,
    output logic       OrigAALU,
    output logic [1:0] OrigBALU,
    output logic [2:0] OpALU,
    output logic       EscreveEPC,
    output logic [5:0] State
);

    state_t state;
    state_t next_state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_RESET:      next_state = S_FETCH;
            S_FETCH:      next_state = S_FETCH_WAIT;
            S_FETCH_WAIT: next_state = S_DECODE;
            S_DECODE: begin
                case (OPcode)
                    OP_RTYPE:      next_state = S_R_EXEC;
                    OP_LW, OP_SW:  next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_J:          next_state = S_JUMP;
                    OP_ADDI:       next_state = S_ADDI_EXEC;
`ifdef CONTROLE_EXCECAO_EN
                    default:       next_state = S_EXC_OPC;
`else
                    default:       next_state = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: begin
                if (OPcode == OP_LW) begin
                    next_state = S_MEM_READ;
                end else if (OPcode == OP_SW) begin
                    next_state = S_SW_WRITE;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_MEM_READ:   next_state = S_MEM_WAIT;
            S_MEM_WAIT:   next_state = S_LW_WB;
            // Overflow is sampled in the execute cycle so the write-back state is never entered.
`ifdef CONTROLE_EXCECAO_EN
            S_R_EXEC:     next_state = Overflow ? S_EXC_OVF : S_R_WB;
            S_ADDI_EXEC:  next_state = Overflow ? S_EXC_OVF : S_ADDI_WB;
`else
            S_R_EXEC:     next_state = S_R_WB;
            S_ADDI_EXEC:  next_state = S_ADDI_WB;
`endif
            default:      next_state = S_FETCH;
        endcase
    end

    always_comb begin
        EscreveMem    = 1'b0;
        EscrevePC     = 1'b0;
        EscrevePCCond = 1'b0;
        PCCondNe      = 1'b0;
        OrigPC        = PC_ALU;
        RegDst        = 1'b0;
        EscreveReg    = 1'b0;
        MemparaReg    = 1'b0;
        IouD          = 1'b0;
        EscreveIR     = 1'b0;
        EscreveMDR    = 1'b0;
        EscreveAluOut = 1'b0;
        OrigAALU      = 1'b0;
        OrigBALU      = B_REG;
        OpALU         = ALU_ADD;
        EscreveEPC    = 1'b0;
        case (state)
            S_FETCH: begin
                OrigBALU  = B_FOUR;
                EscrevePC = 1'b1;
            end
            S_FETCH_WAIT: EscreveIR = 1'b1;
            S_DECODE: begin
                OrigBALU      = B_SEXT_SH2;
                EscreveAluOut = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                OrigAALU      = 1'b1;
                OrigBALU      = B_SEXT;
                EscreveAluOut = 1'b1;
            end
            S_MEM_READ: IouD = 1'b1;
            S_MEM_WAIT: begin
                IouD       = 1'b1;
                EscreveMDR = 1'b1;
            end
            S_LW_WB: begin
                MemparaReg = 1'b1;
                EscreveReg = 1'b1;
            end
            S_SW_WRITE: begin
                IouD       = 1'b1;
                EscreveMem = 1'b1;
            end
            S_R_EXEC: begin
                OrigAALU      = 1'b1;
                OpALU         = ALU_FUNCT;
                EscreveAluOut = 1'b1;
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                EscreveReg = 1'b1;
            end
            S_ADDI_WB: EscreveReg = 1'b1;
            S_BRANCH: begin
                OrigAALU      = 1'b1;
                OpALU         = ALU_SUB;
                OrigPC        = PC_ALUOUT;
                EscrevePCCond = 1'b1;
                PCCondNe      = (OPcode == OP_BNE);
            end
            S_JUMP: begin
                OrigPC    = PC_JUMP;
                EscrevePC = 1'b1;
            end
`ifdef CONTROLE_EXCECAO_EN
            S_EXC_OVF, S_EXC_OPC: begin
                OrigBALU   = B_FOUR;
                OpALU      = ALU_SUB;
                EscreveEPC = 1'b1;
                OrigPC     = PC_EXC;
                EscrevePC  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign State = state;

endmodule

`default_nettype wire

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench: per-cycle expected state/controls queued by stimulus, checked by a negedge monitor.
`default_nettype none

module tb_controle_multiciclo;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] OPcode = 6'h00;
    logic       Overflow = 1'b0;
    logic       EscreveMem, EscrevePC, EscrevePCCond, PCCondNe;
    logic [1:0] OrigPC;
    logic       RegDst, EscreveReg, MemparaReg, IouD, EscreveIR, EscreveMDR, EscreveAluOut, OrigAALU;
    logic [1:0] OrigBALU;
    logic [2:0] OpALU;
    logic       EscreveEPC;
    logic [5:0] State;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [5:0]  st;
        logic [19:0] ctl;
    } exp_t;

    exp_t q[$];

    controle_multiciclo dut (
        .clock(clock), .reset(reset), .OPcode(OPcode), .Overflow(Overflow),
        .EscreveMem(EscreveMem), .EscrevePC(EscrevePC), .EscrevePCCond(EscrevePCCond),
        .PCCondNe(PCCondNe), .OrigPC(OrigPC), .RegDst(RegDst), .EscreveReg(EscreveReg),
        .MemparaReg(MemparaReg), .IouD(IouD), .EscreveIR(EscreveIR), .EscreveMDR(EscreveMDR),
        .EscreveAluOut(EscreveAluOut), .OrigAALU(OrigAALU), .OrigBALU(OrigBALU),
        .OpALU(OpALU), .EscreveEPC(EscreveEPC), .State(State)
    );

    always #5 clock = ~clock;

    // Expected control word per state, taken from the state table.
    // Order: mem pc pccond ne origpc[2] regdst escreg memreg iouD ir mdr aluout a b[2] op[3] epc
    function automatic logic [19:0] ctrl(input logic [5:0] s, input logic [5:0] op);
        case (s)
            6'd1:  return {1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,1'b0};
            6'd2:  return {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0};
            6'd3:  return {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b11,3'b000,1'b0};
            6'd4,
            6'd13: return {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b10,3'b000,1'b0};
            6'd5:  return {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0};
            6'd6:  return {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,1'b0};
            6'd7:  return {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0};
            6'd8:  return {1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0};
            6'd9:  return {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,3'b010,1'b0};
            6'd10: return {1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0};
            6'd11: return {1'b0,1'b0,1'b1,(op == 6'h05),2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,1'b0};
            6'd12: return {1'b0,1'b1,1'b0,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0};
            6'd14: return {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0};
            6'd15,
            6'd16: return {1'b0,1'b1,1'b0,1'b0,2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b001,1'b1};
            default: return 20'd0;
        endcase
    endfunction

    // Queue what the DUT must show in the current cycle, then advance one clock.
    task automatic go(input logic [5:0] st);
        exp_t e;
        e.st  = st;
        e.ctl = ctrl(st, OPcode);
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [19:0] act;
            e = q.pop_front();
            act = {EscreveMem, EscrevePC, EscrevePCCond, PCCondNe, OrigPC, RegDst, EscreveReg,
                   MemparaReg, IouD, EscreveIR, EscreveMDR, EscreveAluOut, OrigAALU, OrigBALU,
                   OpALU, EscreveEPC};
            tests++;
            if (State !== e.st) begin
                fails++;
                $display("FAIL state t=%0t: got %0d expected %0d", $time, State, e.st);
            end
            tests++;
            if (act !== e.ctl) begin
                fails++;
                $display("FAIL controls state=%0d t=%0t: got %b expected %b", e.st, $time, act, e.ctl);
            end
        end
    end

    initial begin
        #20000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        @(posedge clock);
        #1;
        // Reset held low for three sampled edges.
        go(6'd0);
        go(6'd0);
        reset = 1'b1;
        go(6'd0);

        OPcode = 6'h23;
        go(1); go(2); go(3); go(4); go(5); go(6); go(7);

        OPcode = 6'h2B;
        go(1); go(2); go(3); go(4); go(8);

        OPcode = 6'h05;
        go(1); go(2); go(3); go(11);
        OPcode = 6'h04;
        go(1); go(2); go(3); go(11);

        OPcode = 6'h02;
        go(1); go(2); go(3); go(12);

        OPcode = 6'h08;
        Overflow = 1'b0;
        go(1); go(2); go(3); go(13); go(14);

        OPcode = 6'h00;
        go(1); go(2); go(3); go(9); go(10);

        Overflow = 1'b1;
        go(1); go(2); go(3); go(9);
`ifdef CONTROLE_EXCECAO_EN
        go(15);
`else
        go(10);
`endif

        OPcode = 6'h08;
        go(1); go(2); go(3); go(13);
`ifdef CONTROLE_EXCECAO_EN
        go(15);
`else
        go(14);
`endif
        Overflow = 1'b0;

        OPcode = 6'h3F;
        go(1); go(2); go(3);
`ifdef CONTROLE_EXCECAO_EN
        go(16);
`endif

        // Reset asserted while waiting on memory data: write-back must never happen.
        OPcode = 6'h23;
        go(1); go(2); go(3); go(4); go(5);
        reset = 1'b0;
        go(6);
        reset = 1'b1;
        go(0);
        go(1);

        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
